// File: rtl/reg_file_pkg.sv
// Shared widths and types for the architectural register file and its read ports.
// The ROB id width must hold 0 (no tag) plus ids 1..RO_BUFFER_SIZE.
package reg_file_pkg;

  localparam int REG_W          = 32;
  localparam int REG_ID_W       = 5;
  localparam int REG_FILE_SIZE  = 32;
  localparam int RO_BUFFER_SIZE = 16;
  localparam int ROB_ID_W       = $clog2(RO_BUFFER_SIZE + 1);

  typedef logic [REG_W-1:0]    reg_t;
  typedef logic [REG_ID_W-1:0] reg_id_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;

  // A commit only touches state when it names a real ROB entry and a non-zero rd.
  function automatic logic is_commit(input rob_id_t dest, input reg_id_t rd);
    return (dest != '0) && (rd != '0);
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational operand read port: x0, commit bypass, pending tag, stored value.
// Zero latency; no flow control, output follows inputs within the cycle.
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  logic [REG_ID_W-1:0] rs,
  input  logic [REG_W-1:0]    values    [REG_FILE_SIZE],
  input  logic [ROB_ID_W-1:0] tags      [REG_FILE_SIZE],
  input  logic                commit_vld,
  input  logic [REG_ID_W-1:0] commit_rd,
  input  logic [ROB_ID_W-1:0] commit_dest,
  input  logic [REG_W-1:0]    commit_dat,
  output logic [ROB_ID_W-1:0] q,
  output logic [REG_W-1:0]    v
);

  logic [ROB_ID_W-1:0] rs_tag;
  logic [REG_W-1:0]    rs_val;
  logic                bypass_hit;

  assign rs_tag     = tags[rs];
  assign rs_val     = values[rs];
  // Only a commit that retires the live rename may forward its value.
  assign bypass_hit = commit_vld && (commit_rd == rs) && (rs_tag == commit_dest);

  always_comb begin
    q = '0;
    v = '0;
    if (rs == '0) begin
      q = '0;
      v = '0;
    end else if (bypass_hit) begin
      q = '0;
      v = commit_dat;
    end else if (rs_tag != '0) begin
      q = rs_tag;
      v = '0;
    end else begin
      q = '0;
      v = rs_val;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags: commit writes next edge, reads are combinational.
// rdy low freezes all state (flush included); async active-low reset clears everything.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                reset_from_rob_bus,
  input  logic [ROB_ID_W-1:0] dest_from_ro_buffer,
  input  logic [REG_ID_W-1:0] rd_from_ro_buffer,
  input  logic [REG_W-1:0]    value_from_ro_buffer,
  input  logic                valid_from_issuer,
  input  logic [REG_ID_W-1:0] rd_from_issuer,
  input  logic [ROB_ID_W-1:0] dest_from_issuer,
  input  logic [REG_ID_W-1:0] rs1_from_issuer,
  input  logic [REG_ID_W-1:0] rs2_from_issuer,
  output logic [ROB_ID_W-1:0] qj_to_issuer,
  output logic [ROB_ID_W-1:0] qk_to_issuer,
  output logic [REG_W-1:0]    vj_to_issuer,
  output logic [REG_W-1:0]    vk_to_issuer,
  output logic [31:0]         commit_count
);

  logic [REG_W-1:0]    value_q [REG_FILE_SIZE];
  logic [REG_W-1:0]    value_d [REG_FILE_SIZE];
  logic [ROB_ID_W-1:0] tag_q   [REG_FILE_SIZE];
  logic [ROB_ID_W-1:0] tag_d   [REG_FILE_SIZE];
  logic [31:0]         commit_count_q;
  logic [31:0]         commit_count_d;

  logic commit_vld;
  logic issue_vld;

  assign commit_vld = is_commit(dest_from_ro_buffer, rd_from_ro_buffer);
  assign issue_vld  = valid_from_issuer && (rd_from_issuer != '0);

  always_comb begin
    value_d        = value_q;
    tag_d          = tag_q;
    commit_count_d = commit_count_q;
    if (rdy) begin
      if (commit_vld) begin
        value_d[rd_from_ro_buffer] = value_from_ro_buffer;
        commit_count_d             = commit_count_q + 32'd1;
        // A younger rename keeps its tag; only the matching commit clears it.
        if (tag_q[rd_from_ro_buffer] == dest_from_ro_buffer) begin
          tag_d[rd_from_ro_buffer] = '0;
        end
      end
      // Flush drops every rename and the same-cycle issue; the issue tag otherwise overrides a commit clear.
      if (reset_from_rob_bus) begin
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
          tag_d[i] = '0;
        end
      end else if (issue_vld) begin
        tag_d[rd_from_issuer] = dest_from_issuer;
      end
    end
    value_d[0] = '0;
    tag_d[0]   = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      commit_count_q <= '0;
    end else begin
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        value_q[i] <= value_d[i];
        tag_q[i]   <= tag_d[i];
      end
      commit_count_q <= commit_count_d;
    end
  end

  assign commit_count = commit_count_q;

  reg_file_read_port u_rs1_port (
    .rs          (rs1_from_issuer),
    .values      (value_q),
    .tags        (tag_q),
    .commit_vld  (commit_vld),
    .commit_rd   (rd_from_ro_buffer),
    .commit_dest (dest_from_ro_buffer),
    .commit_dat  (value_from_ro_buffer),
    .q           (qj_to_issuer),
    .v           (vj_to_issuer)
  );

  reg_file_read_port u_rs2_port (
    .rs          (rs2_from_issuer),
    .values      (value_q),
    .tags        (tag_q),
    .commit_vld  (commit_vld),
    .commit_rd   (rd_from_ro_buffer),
    .commit_dest (dest_from_ro_buffer),
    .commit_dat  (value_from_ro_buffer),
    .q           (qk_to_issuer),
    .v           (vk_to_issuer)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios then randomized traffic against a reference model.
module tb_reg_file;
  import reg_file_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                rdy;
  logic                flush;
  logic [ROB_ID_W-1:0] c_dest;
  logic [REG_ID_W-1:0] c_rd;
  logic [REG_W-1:0]    c_val;
  logic                i_vld;
  logic [REG_ID_W-1:0] i_rd;
  logic [ROB_ID_W-1:0] i_dest;
  logic [REG_ID_W-1:0] rs1;
  logic [REG_ID_W-1:0] rs2;
  logic [ROB_ID_W-1:0] qj;
  logic [ROB_ID_W-1:0] qk;
  logic [REG_W-1:0]    vj;
  logic [REG_W-1:0]    vk;
  logic [31:0]         commit_count;

  int vectors;
  int miscompares;

  // Reference state, indexed by architectural register number.
  int unsigned m_val [32];
  int unsigned m_tag [32];
  int unsigned m_cnt;

  reg_file dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rdy                  (rdy),
    .reset_from_rob_bus   (flush),
    .dest_from_ro_buffer  (c_dest),
    .rd_from_ro_buffer    (c_rd),
    .value_from_ro_buffer (c_val),
    .valid_from_issuer    (i_vld),
    .rd_from_issuer       (i_rd),
    .dest_from_issuer     (i_dest),
    .rs1_from_issuer      (rs1),
    .rs2_from_issuer      (rs2),
    .qj_to_issuer         (qj),
    .qk_to_issuer         (qk),
    .vj_to_issuer         (vj),
    .vk_to_issuer         (vk),
    .commit_count         (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 0;
      m_tag[i] = 0;
    end
    m_cnt = 0;
  endfunction

  // Expected operand for register r given the inputs currently presented.
  function automatic void model_read(input int unsigned r, output int unsigned q, output int unsigned v);
    bit commit;
    commit = (c_dest != 0) && (c_rd != 0);
    if (r == 0) begin
      q = 0; v = 0;
    end else if (commit && c_rd == r && m_tag[r] == c_dest) begin
      q = 0; v = c_val;
    end else if (m_tag[r] != 0) begin
      q = m_tag[r]; v = 0;
    end else begin
      q = 0; v = m_val[r];
    end
  endfunction

  function automatic void model_edge();
    if (!rdy) return;
    if (c_dest != 0 && c_rd != 0) begin
      m_val[c_rd] = c_val;
      m_cnt       = m_cnt + 1;
      if (m_tag[c_rd] == c_dest) m_tag[c_rd] = 0;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_tag[i] = 0;
    end else if (i_vld && i_rd != 0) begin
      m_tag[i_rd] = i_dest;
    end
  endfunction

  function automatic void idle();
    rdy = 1'b1; flush = 1'b0;
    c_dest = '0; c_rd = '0; c_val = '0;
    i_vld = 1'b0; i_rd = '0; i_dest = '0;
  endfunction

  // Called just after a falling edge with inputs set: check reads, take the rising edge, advance the model.
  task automatic tick();
    int unsigned eq, ev;
    #1;
    model_read(rs1, eq, ev);
    if (rdy || c_dest == 0 || c_rd != rs1) begin
      check("qj", 32'(qj), eq);
      check("vj", vj, ev);
    end
    model_read(rs2, eq, ev);
    if (rdy || c_dest == 0 || c_rd != rs2) begin
      check("qk", 32'(qk), eq);
      check("vk", vk, ev);
    end
    check("commit_count", commit_count, m_cnt);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    rs1 = 5'd5; rs2 = 5'd31;
    #1;
    model_reset();
    check("rst_qj", 32'(qj), 0);
    check("rst_vj", vj, 0);
    check("rst_qk", 32'(qk), 0);
    check("rst_vk", vk, 0);
    check("rst_count", commit_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    idle();
    rs1 = '0; rs2 = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Rename then commit with same-cycle bypass.
    i_vld = 1'b1; i_rd = 5'd3; i_dest = 5'd4;
    tick();
    idle(); rs1 = 5'd3;
    #1; check("rename_qj", 32'(qj), 32'd4);
    tick();
    c_dest = 5'd4; c_rd = 5'd3; c_val = 32'hDEADBEEF; rs1 = 5'd3;
    #1; check("bypass_qj", 32'(qj), 32'd0); check("bypass_vj", vj, 32'hDEADBEEF);
    tick();
    idle();
    #1; check("stored_vj", vj, 32'hDEADBEEF); check("count_1", commit_count, 32'd1);
    tick();

    // Stale commit keeps the younger rename.
    i_vld = 1'b1; i_rd = 5'd7; i_dest = 5'd2; tick();
    i_dest = 5'd5; tick();
    idle(); c_dest = 5'd2; c_rd = 5'd7; c_val = 32'h11; rs2 = 5'd7; tick();
    idle();
    #1; check("stale_qk", 32'(qk), 32'd5);
    tick();

    // Same-cycle issue and commit on x9: issue tag wins, value still written.
    i_vld = 1'b1; i_rd = 5'd9; i_dest = 5'd3; tick();
    c_dest = 5'd3; c_rd = 5'd9; c_val = 32'h99; i_dest = 5'd6; rs1 = 5'd9; tick();
    idle();
    #1; check("same_rd_qj", 32'(qj), 32'd6);
    tick();
    c_dest = 5'd6; c_rd = 5'd9; c_val = 32'h1234; tick();

    // Flush with a coincident commit and issue.
    i_vld = 1'b1; i_rd = 5'd1; i_dest = 5'd1; tick();
    i_rd = 5'd2; i_dest = 5'd9; tick();
    i_rd = 5'd10; i_dest = 5'd11; tick();
    flush = 1'b1; c_dest = 5'd1; c_rd = 5'd1; c_val = 32'h1000; i_rd = 5'd4; i_dest = 5'd8; tick();
    idle(); rs1 = 5'd1; rs2 = 5'd4;
    #1; check("flush_vj", vj, 32'h1000); check("flush_qk", 32'(qk), 32'd0);
    tick();
    rs1 = 5'd2; rs2 = 5'd10; tick();

    // x0 is never written or renamed.
    i_vld = 1'b1; i_rd = 5'd0; i_dest = 5'd7; c_dest = 5'd2; c_rd = 5'd0; c_val = 32'hFFFF; rs1 = 5'd0; tick();
    idle(); tick();

    // rdy low freezes everything.
    i_vld = 1'b1; i_rd = 5'd12; i_dest = 5'd13; tick();
    rdy = 1'b0; flush = 1'b1; i_rd = 5'd14; i_dest = 5'd3; c_dest = 5'd9; c_rd = 5'd15; c_val = 32'h55;
    rs1 = 5'd12; rs2 = 5'd14; tick();
    idle(); rs1 = 5'd12; rs2 = 5'd15;
    #1; check("rdy_hold_qj", 32'(qj), 32'd13); check("rdy_hold_vk", vk, 32'd0);
    tick();

    async_reset();
    idle(); tick();

    // Randomized traffic concentrated on a few registers so renames collide.
    for (int n = 0; n < 3000; n++) begin
      rdy    = ($urandom_range(9) != 0);
      flush  = ($urandom_range(24) == 0);
      c_dest = ($urandom_range(3) == 0) ? '0 : ROB_ID_W'($urandom_range(RO_BUFFER_SIZE, 1));
      c_rd   = ($urandom_range(3) == 0) ? REG_ID_W'($urandom_range(31)) : REG_ID_W'($urandom_range(6));
      c_val  = $urandom;
      i_vld  = $urandom_range(1);
      i_rd   = REG_ID_W'($urandom_range(6));
      i_dest = ROB_ID_W'($urandom_range(RO_BUFFER_SIZE, 1));
      rs1    = REG_ID_W'($urandom_range(7));
      rs2    = ($urandom_range(3) == 0) ? REG_ID_W'($urandom_range(31)) : REG_ID_W'($urandom_range(6));
      // A commit usually retires a live rename so tag clears and bypasses are exercised.
      if (c_rd != 0 && m_tag[c_rd] != 0 && $urandom_range(1) == 1) c_dest = ROB_ID_W'(m_tag[c_rd]);
      if (n == 1500) async_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
